// File: rtl/pcpu_pkg.sv
// pcpu_pkg: shared FSM state and owner encodings for the pipelined CPU memory arbiter.
// No ports; imported by pcpu_mem_arbiter and arb_select.
package pcpu_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;
endpackage

// File: rtl/pcpu_mem_arbiter_if.sv
// pcpu_mem_arbiter_if: IF/MEM request-response channels plus the shared memory port.
// Ports (signals): if_req/if_addr/if_ready/if_rdata fetch channel; dm_req/dm_we/dm_addr/dm_wdata/
// dm_ready/dm_rdata data channel; mem_en/mem_we/mem_addr/mem_wdata/mem_rdata memory port.
// slave = arbiter side, master = CPU stages plus memory side.
interface pcpu_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ready;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ready, if_rdata, dm_ready, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ready, if_rdata, dm_ready, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/pcpu_mem_arbiter_arb_select.sv
// arb_select: data-over-fetch priority with a starvation guard that lets fetch through.
// Ports: clk_in clock; reset async active-low; if_req/dm_req pending requests;
// grant strobe when the arbiter takes a grant; owner selected requester (OWN_IF/OWN_DM).
module arb_select
    import pcpu_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk_in,
    input  logic reset,
    input  logic if_req,
    input  logic dm_req,
    input  logic grant,
    output logic owner
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_q, starve_d;

    assign owner = dm_req && !(if_req && starve_q == SW'(STARVE_MAX)) ? OWN_DM : OWN_IF;
    // A contested data grant only occurs below STARVE_MAX, so the increment saturates by construction.
    assign starve_d = !grant ? starve_q : owner == OWN_DM && if_req ? starve_q + SW'(1) : '0;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) starve_q <= '0;
        else starve_q <= starve_d;
    end
endmodule

// File: rtl/pcpu_mem_arbiter.sv
// pcpu_mem_arbiter: shares one synchronous single-port memory between the IF and MEM stages.
// Ports: clk_in clock; reset async active-low; enable gates new grants; busy high outside IDLE;
// bus (slave) carries the fetch/data request channels and the memory port. All outputs registered.
module pcpu_mem_arbiter
    import pcpu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic clk_in,
    input  logic reset,
    input  logic enable,
    output logic busy,
    pcpu_mem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic owner_q, owner_d, we_q, we_d, sel, grant;
    logic mem_en_q, mem_en_d, mem_we_q, mem_we_d, busy_q, busy_d;
    logic if_ready_q, if_ready_d, dm_ready_q, dm_ready_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;

    assign grant = state_q == IDLE && enable && (bus.if_req || bus.dm_req);

    arb_select #(.STARVE_MAX(STARVE_MAX)) u_sel (
        .clk_in(clk_in),
        .reset (reset),
        .if_req(bus.if_req),
        .dm_req(bus.dm_req),
        .grant (grant),
        .owner (sel)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        if_ready_d = 1'b0;
        dm_ready_d = 1'b0;
        case (state_q)
            IDLE: if (grant) begin
                state_d  = ISSUE;
                owner_d  = sel;
                we_d     = sel == OWN_DM && bus.dm_we;
                addr_d   = sel == OWN_DM ? bus.dm_addr : bus.if_addr;
                wdata_d  = bus.dm_wdata;
                // Strobes are registered at grant so they are on the port throughout ISSUE.
                mem_en_d = 1'b1;
                mem_we_d = we_d;
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CNT_W'(MEM_LAT);
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = RESP;
                    if_rdata_d = owner_q == OWN_IF ? bus.mem_rdata : if_rdata_q;
                    dm_rdata_d = owner_q == OWN_DM && !we_q ? bus.mem_rdata : dm_rdata_q;
                    if_ready_d = owner_q == OWN_IF;
                    dm_ready_d = owner_q == OWN_DM;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            if_ready_q <= if_ready_d;
            dm_ready_q <= dm_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_ready  = dm_ready_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_pcpu_mem_arbiter.sv
// tb_pcpu_mem_arbiter: directed and randomized checks of pcpu_mem_arbiter against a transaction-level model.
module tb_pcpu_mem_arbiter;
    localparam int LAT  = 2;
    localparam int SMAX = 2;

    logic clk_in = 1'b0;
    logic reset  = 1'b0;
    logic enable = 1'b0;
    logic busy;

    pcpu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    pcpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk_in(clk_in),
        .reset (reset),
        .enable(enable),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit auto_mode = 0;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    int mem_due = -100;
    logic [31:0] mem_val;
    int g_cyc, free_at, starve;
    bit g_dm, g_we;
    logic [31:0] g_addr, g_wdata, g_rd, exp_if_rd, exp_dm_rd;
    logic [31:0] obs_addr [$];

    function automatic logic [31:0] memf(int i);
        return i == 16 ? 32'h24020001 : 32'hA5000000 ^ (32'(i) * 32'h00010203);
    endfunction

    function automatic logic [31:0] raddr();
        return 32'($urandom_range(0, 31)) << 2;
    endfunction

    task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h want %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        g_cyc = -100;
        free_at = 0;
        starve = 0;
        exp_if_rd = '0;
        exp_dm_rd = '0;
    endtask

    // One access per grant: strobe one cycle later, ready LAT+2 later, idle again LAT+3 later.
    task automatic model_step();
        bit dm;
        if (!reset) model_reset();
        else if (cyc >= free_at && enable && (bus.if_req || bus.dm_req)) begin
            dm = bus.dm_req && !(bus.if_req && starve == SMAX);
            starve = dm && bus.if_req ? starve + 1 : 0;
            g_cyc = cyc;
            g_dm = dm;
            g_we = dm && bus.dm_we;
            g_addr = dm ? bus.dm_addr : bus.if_addr;
            g_wdata = bus.dm_wdata;
            if (g_we) ref_mem[g_addr[9:2]] = g_wdata;
            else g_rd = ref_mem[g_addr[9:2]];
            free_at = cyc + LAT + 3;
        end
    endtask

    task automatic check();
        bit en, rdy;
        en = cyc == g_cyc + 1;
        rdy = cyc == g_cyc + LAT + 2;
        if (rdy && !g_we) begin
            if (g_dm) exp_dm_rd = g_rd;
            else exp_if_rd = g_rd;
        end
        if (bus.mem_en) obs_addr.push_back(bus.mem_addr);
        chk("busy", busy, cyc > g_cyc && cyc <= g_cyc + LAT + 2);
        chk("mem_en", bus.mem_en, en);
        chk("mem_we", bus.mem_en & bus.mem_we, en & g_we);
        if (en) chk("mem_addr", bus.mem_addr, g_addr);
        if (en && g_we) chk("mem_wdata", bus.mem_wdata, g_wdata);
        chk("if_ready", bus.if_ready, rdy && !g_dm);
        chk("dm_ready", bus.dm_ready, rdy && g_dm);
        chk("if_rdata", bus.if_rdata, exp_if_rd);
        chk("dm_rdata", bus.dm_rdata, exp_dm_rd);
    endtask

    // Memory device: read data is presented only around the edge LAT cycles after the strobe.
    task automatic mem_io();
        bus.mem_rdata = cyc == mem_due ? mem_val : $urandom;
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
            else begin
                mem_due = cyc + LAT;
                mem_val = mem[bus.mem_addr[9:2]];
            end
        end
    endtask

    task automatic gen();
        bit rdy, act;
        rdy = cyc == g_cyc + LAT + 2;
        act = cyc > g_cyc && cyc < g_cyc + LAT + 2;
        if (rdy) begin
            if (g_dm) bus.dm_req = 1'b0;
            else bus.if_req = 1'b0;
        end
        if (act && g_dm) begin
            bus.dm_addr = raddr();
            bus.dm_we = 1'($urandom);
            bus.dm_wdata = $urandom;
        end
        if (act && !g_dm) bus.if_addr = raddr();
        if (!bus.if_req && $urandom_range(0, 1) == 1) begin
            bus.if_req = 1'b1;
            bus.if_addr = raddr();
        end
        if (!bus.dm_req && $urandom_range(0, 1) == 1) begin
            bus.dm_req = 1'b1;
            bus.dm_addr = raddr();
            bus.dm_we = 1'($urandom);
            bus.dm_wdata = $urandom;
        end
        enable = $urandom_range(0, 7) != 0;
    endtask

    // Inputs currently driven are what the DUT samples at the end of this cycle.
    task automatic tick();
        model_step();
        @(negedge clk_in);
        cyc++;
        check();
        mem_io();
        if (auto_mode) gen();
    endtask

    initial begin
        logic [31:0] order [6];
        order = '{32'h200, 32'h200, 32'h80, 32'h200, 32'h200, 32'h80};
        for (int i = 0; i < 256; i++) begin
            mem[i] = memf(i);
            ref_mem[i] = memf(i);
        end
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.dm_req = 1'b0;
        bus.dm_we = 1'b0;
        bus.dm_addr = '0;
        bus.dm_wdata = '0;
        bus.mem_rdata = '0;
        model_reset();
        @(negedge clk_in);

        for (int i = 0; i < 6; i++) begin
            bus.if_req = 1'($urandom);
            bus.dm_req = 1'($urandom);
            bus.dm_we = 1'($urandom);
            bus.if_addr = $urandom;
            bus.dm_addr = $urandom;
            bus.dm_wdata = $urandom;
            enable = 1'($urandom);
            tick();
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        bus.dm_we = 1'b0;
        enable = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        chk("idle_busy", busy, 0);

        bus.if_req = 1'b1;
        bus.if_addr = 32'h40;
        tick();
        chk("s2_en", bus.mem_en, 1);
        chk("s2_addr", bus.mem_addr, 32'h40);
        repeat (3) tick();
        chk("s2_rdy", bus.if_ready, 1);
        chk("s2_rdata", bus.if_rdata, 32'h24020001);
        bus.if_req = 1'b0;
        tick();

        bus.dm_req = 1'b1;
        bus.dm_we = 1'b0;
        bus.dm_addr = 32'h100;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h44;
        repeat (4) tick();
        chk("s3_dm_rdy", bus.dm_ready, 1);
        chk("s3_dm_rdata", bus.dm_rdata, memf(64));
        bus.dm_req = 1'b0;
        repeat (2) tick();
        chk("s3_if_en", bus.mem_en, 1);
        chk("s3_if_addr", bus.mem_addr, 32'h44);
        repeat (3) tick();
        chk("s3_if_rdy", bus.if_ready, 1);
        bus.if_req = 1'b0;
        tick();

        obs_addr.delete();
        bus.dm_req = 1'b1;
        bus.dm_addr = 32'h200;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h80;
        repeat (30) tick();
        bus.dm_req = 1'b0;
        bus.if_req = 1'b0;
        for (int i = 0; i < 6; i++)
            chk("s4_order", i < obs_addr.size() ? obs_addr[i] : '1, order[i]);
        tick();

        enable = 1'b0;
        bus.dm_req = 1'b1;
        bus.dm_we = 1'b1;
        bus.dm_addr = 32'h300;
        bus.dm_wdata = 32'hDEADBEEF;
        repeat (5) begin
            tick();
            chk("s5_hold", bus.mem_en, 0);
        end
        enable = 1'b1;
        tick();
        chk("s5_en", bus.mem_en, 1);
        chk("s5_we", bus.mem_we, 1);
        chk("s5_wdata", bus.mem_wdata, 32'hDEADBEEF);
        repeat (3) tick();
        chk("s5_rdy", bus.dm_ready, 1);
        chk("s5_rdata", bus.dm_rdata, memf(128));
        bus.dm_req = 1'b0;
        bus.dm_we = 1'b0;
        tick();

        bus.dm_req = 1'b1;
        bus.dm_addr = 32'h100;
        repeat (2) tick();
        chk("s6_busy_pre", busy, 1);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("s6_busy", busy, 0);
        chk("s6_mem_en", bus.mem_en, 0);
        chk("s6_mem_addr", bus.mem_addr, 0);
        chk("s6_if_rdata", bus.if_rdata, 0);
        chk("s6_dm_rdata", bus.dm_rdata, 0);
        bus.dm_req = 1'b0;
        repeat (4) begin
            tick();
            chk("s6_no_rdy", bus.dm_ready, 0);
        end
        reset = 1'b1;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h40;
        tick();
        chk("s6_en", bus.mem_en, 1);
        repeat (3) tick();
        chk("s6_rdy", bus.if_ready, 1);
        chk("s6_rdata", bus.if_rdata, 32'h24020001);
        bus.if_req = 1'b0;
        tick();

        auto_mode = 1;
        repeat (2000) tick();
        auto_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pcpu_mem_arbiter.md
# pcpu_mem_arbiter

Shares one synchronous single-port memory between the pipelined CPU's instruction-fetch (IF) stage and data-memory (MEM) stage. Each access runs through a small FSM: sample requests, grant one owner, drive the memory port, wait a fixed latency, then return registered read data with a one-cycle ready pulse. Grants follow fixed data-over-fetch priority with a starvation guard. The block sits between the CPU core's IF/MEM stages and the unified memory inside `top`.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `MEM_LAT`, 2, memory read latency in cycles, ≥1.
- `STARVE_MAX`, 4, consecutive data grants allowed while fetch waits, ≥1.

Ports:
- `clk_in` in 1: clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: when low, no new grants are made. An in-flight access still completes.
- `if_req` in 1: fetch request. Held until `if_ready`.
- `if_addr` in ADDR_W: fetch address.
- `if_ready` out 1: one-cycle pulse; fetch access complete.
- `if_rdata` out DATA_W: fetch data, valid while `if_ready`=1.
- `dm_req` in 1: data request. Held until `dm_ready`.
- `dm_we` in 1: 1 = write, 0 = read.
- `dm_addr` in ADDR_W: data address.
- `dm_wdata` in DATA_W: write data.
- `dm_ready` out 1: one-cycle pulse; data access complete (reads and writes).
- `dm_rdata` out DATA_W: read data, valid while `dm_ready`=1. Unchanged after a write.
- `mem_en` out 1: memory access strobe, one cycle per access.
- `mem_we` out 1: memory write enable, qualified by `mem_en`.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, valid `MEM_LAT` cycles after the `mem_en` cycle.
- `busy` out 1: high when state ≠ IDLE.

## Operation
States:
- IDLE: if `enable`=1 and any request is pending, select an owner, latch the owner and the request fields, and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: assert `mem_en`, `mem_we`, `mem_addr`, `mem_wdata` from the latched request. Load the wait counter with `MEM_LAT`. Go to WAIT.
- WAIT: decrement the counter each cycle. At counter = 1, capture `mem_rdata` (for reads) into the owner's rdata register. Go to RESP.
- RESP: pulse the owner's `*_ready`. Go to IDLE. Both requests are ignored in this cycle.

Arbitration (evaluated only in IDLE):
- Only `dm_req`: grant data.
- Only `if_req`: grant fetch.
- Both pending: grant data unless `starve_cnt` = `STARVE_MAX`, in which case grant fetch.
- `starve_cnt` increments on a data grant made while `if_req`=1. It clears on any fetch grant, or on a data grant made while `if_req`=0. It saturates at `STARVE_MAX`.

Rules:
- Request fields are latched at grant. Later changes on the request bus have no effect until the next grant.
- `enable` low in ISSUE, WAIT or RESP does not abort the access.

Reset (asynchronous, mid-operation included):
- State goes to IDLE.
- All outputs go to 0: `mem_*`, `*_ready`, `*_rdata`, `busy`.
- `starve_cnt` goes to 0.
- An in-flight access is abandoned and no ready pulse is issued for it.

Widths:
- Wait counter is `$clog2(MEM_LAT+1)` bits.
- `starve_cnt` is `$clog2(STARVE_MAX+1)` bits.

## Timing
- Request sampled in IDLE at cycle k: `mem_en`=1 at k+1, `mem_rdata` sampled at k+1+MEM_LAT, `*_ready`=1 at k+2+MEM_LAT, IDLE again at k+3+MEM_LAT.
- Throughput: one access per `MEM_LAT`+3 cycles. A requester may present its next request in the cycle after its ready pulse.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package `pcpu_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - owner encoding `OWN_IF`=0, `OWN_DM`=1.
- One sub-module, `arb_select`: owns the priority decision and `starve_cnt`. Inputs: `if_req`, `dm_req`, grant strobe. Output: selected owner.

## Test plan
All scenarios use `MEM_LAT`=2 and `STARVE_MAX`=2.
1. Reset:
   - Hold `reset`=0 with random inputs → every output is 0 and `busy`=0.
   - Release `reset` → the block stays idle until a request arrives.
2. Single fetch:
   - Stimulus: `if_req` with `if_addr`=0x00000040 at cycle 0; memory returns 0x24020001.
   - Required: `mem_en`=1 with `mem_addr`=0x40 at cycle 1; `if_ready`=1 with `if_rdata`=0x24020001 at cycle 4.
3. Simultaneous requests:
   - Stimulus: `dm_req` (read, 0x100) and `if_req` (0x44) both at cycle 0.
   - Required: `dm_ready` at cycle 4, then `mem_en` for address 0x44 at cycle 6 and `if_ready` at cycle 9.
4. Starvation guard:
   - Stimulus: `if_req` and `dm_req` held high continuously.
   - Required: grant order dm, dm, if, dm, dm, if.
5. Enable and write:
   - Stimulus: `enable`=0 with `dm_req` pending.
   - Required: no `mem_en` is issued.
   - Then: raise `enable` at cycle c → `mem_en`=1, `mem_we`=1 at c+1 with `dm_wdata`=0xDEADBEEF. `dm_ready` at c+4; `dm_rdata` unchanged.
6. Reset mid-operation:
   - Stimulus: assert `reset` during WAIT.
   - Required: no ready pulse, outputs 0 immediately.
   - After release: a fresh fetch completes with standard `MEM_LAT`+2 latency.
